// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every non-clock, non-reset signal of mem_port_arbiter.
//   Fetch side : if_req, if_addr (in)    if_rdata, if_ready (out)
//   Data side  : mem_rd, mem_wr, mem_addr, mem_wdata (in)    mem_rdata, mem_ready (out)
//   SRAM pads  : sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n (out)    sram_dq_in (in)
//   Pipeline   : freeze (out), stalls every stage register
// The slave modport is the arbiter's view; master is the pipeline/board view.
interface mem_port_arbiter_if #(
   parameter int SRAM_AW = 18
);
   logic                if_req;
   logic [31:0]         if_addr;
   logic [31:0]         if_rdata;
   logic                if_ready;

   logic                mem_rd;
   logic                mem_wr;
   logic [31:0]         mem_addr;
   logic [31:0]         mem_wdata;
   logic [31:0]         mem_rdata;
   logic                mem_ready;

   logic [SRAM_AW-1:0]  sram_addr;
   logic [31:0]         sram_dq_out;
   logic                sram_dq_oe;
   logic [31:0]         sram_dq_in;
   logic                sram_we_n;
   logic                sram_oe_n;

   logic                freeze;

   modport slave (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_dq_in,
      output if_rdata, if_ready, mem_rdata, mem_ready,
             sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, freeze
   );

   modport master (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, sram_dq_in,
      input  if_rdata, if_ready, mem_rdata, mem_ready,
             sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, freeze
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port SRAM between the fetch stage and the memory stage.
// Every access is a WAIT_CYCLES-long ACCESS phase followed by one IDLE cycle.
// The memory stage wins when both ask, since it holds the older instruction.
// freeze holds the whole pipeline until every request of the current step
// has been served; the per-requester done flags stop a held request from
// being serviced twice in the same step.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : mem_port_arbiter_if.slave (fetch, data, SRAM pad and freeze signals)
module mem_port_arbiter #(
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic             mem_done_f;
   logic             if_done_f;
   logic             acc_mem;
   logic             acc_write;

   logic             mem_pend;
   logic             if_pend;
   logic             start;
   logic             finish;
   logic             grant_write;
   logic [SRAM_AW-1:0] grant_addr;
   logic             unused_addr_bits;

   // Only the word-address bits reach the pads; the rest are ignored.
   assign unused_addr_bits = ^bus.if_addr ^ ^bus.mem_addr;

   // A requester is pending until it has been served in this pipeline step.
   assign mem_pend = (bus.mem_rd | bus.mem_wr) & ~mem_done_f;
   assign if_pend  = bus.if_req & ~if_done_f;

   // Memory stage has priority; a simultaneous read and write counts as a write.
   assign grant_write = mem_pend & bus.mem_wr;
   assign grant_addr  = mem_pend ? bus.mem_addr[SRAM_AW+1:2] : bus.if_addr[SRAM_AW+1:2];

   // Combinational stall, gated by reset so the pipeline is released at once.
   assign bus.freeze = rst & ((state == ACCESS) | mem_pend | if_pend);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start a transaction from IDLE when anything is pending,
   // finish it when the wait counter has run out.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (mem_pend | if_pend) begin
               start      = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transaction datapath: pad controls are registered on entry to ACCESS and
   // restored on exit, read data and done flags are captured on exit, and
   // ready pulses for exactly the one IDLE cycle that follows.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= '0;
         mem_done_f    <= 1'b0;
         if_done_f     <= 1'b0;
         acc_mem       <= 1'b0;
         acc_write     <= 1'b0;
         bus.sram_addr   <= '0;
         bus.sram_dq_out <= '0;
         bus.sram_dq_oe  <= 1'b0;
         bus.sram_we_n   <= 1'b1;
         bus.sram_oe_n   <= 1'b1;
         bus.if_rdata    <= '0;
         bus.mem_rdata   <= '0;
         bus.if_ready    <= 1'b0;
         bus.mem_ready   <= 1'b0;
      end else begin
         bus.if_ready  <= 1'b0;
         bus.mem_ready <= 1'b0;

         if (start) begin
            cnt             <= CW'(WAIT_CYCLES - 1);
            acc_mem         <= mem_pend;
            acc_write       <= grant_write;
            bus.sram_addr   <= grant_addr;
            bus.sram_dq_out <= bus.mem_wdata;
            bus.sram_dq_oe  <= grant_write;
            bus.sram_we_n   <= ~grant_write;
            bus.sram_oe_n   <= grant_write;
         end else if (finish) begin
            bus.sram_dq_oe <= 1'b0;
            bus.sram_we_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            if (acc_mem) begin
               mem_done_f    <= 1'b1;
               bus.mem_ready <= 1'b1;
               if (!acc_write) begin
                  bus.mem_rdata <= bus.sram_dq_in;
               end
            end else begin
               if_done_f    <= 1'b1;
               bus.if_ready <= 1'b1;
               bus.if_rdata <= bus.sram_dq_in;
            end
         end else if (state == ACCESS) begin
            cnt <= cnt - 1'b1;
         end

         // The pipeline advances on this edge, so a new step begins with
         // neither requester marked as served.
         if ((state == IDLE) && !bus.freeze) begin
            mem_done_f <= 1'b0;
            if_done_f  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances share clk/rst: one with
// WAIT_CYCLES=4 for the main scenarios and one with WAIT_CYCLES=1.
// Stimulus pushes expected ready events (source, data, cycle) into a queue;
// an independent monitor pops and compares on every ready pulse.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          dut;
      bit          is_if;
      bit          chk_data;
      logic [31:0] data;
      int          cycle;
   } exp_t;

   exp_t q[$];

   mem_port_arbiter_if #(.SRAM_AW(18)) bus4();
   mem_port_arbiter_if #(.SRAM_AW(18)) bus1();

   mem_port_arbiter #(.SRAM_AW(18), .WAIT_CYCLES(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   mem_port_arbiter #(.SRAM_AW(18), .WAIT_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // 10 ns clock and a cycle counter that advances on each rising edge.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: asynchronous read while oe_n is low, write on the
   // clock edge while the write strobe and pad driver are both active.
   logic [31:0] sram_mem [0:1023];

   assign bus4.sram_dq_in = bus4.sram_oe_n ? 32'h0 : sram_mem[bus4.sram_addr[9:0]];
   assign bus1.sram_dq_in = bus1.sram_oe_n ? 32'h0 : sram_mem[bus1.sram_addr[9:0]];

   always @(posedge clk) begin
      if (!bus4.sram_we_n && bus4.sram_dq_oe) begin
         sram_mem[bus4.sram_addr[9:0]] <= bus4.sram_dq_out;
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_ready(input int dut, input bit is_if, input bit chk, input logic [31:0] data, input int cycle);
      exp_t e;
      e.dut      = dut;
      e.is_if    = is_if;
      e.chk_data = chk;
      e.data     = data;
      e.cycle    = cycle;
      q.push_back(e);
   endtask

   task automatic score(input int dut, input bit is_if, input logic [31:0] rdata);
      exp_t e;
      if (q.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL unexpected_ready: dut=%0d is_if=%0b pulsed at cycle %0d, required no pulse", dut, is_if, cyc);
         return;
      end
      e = q.pop_front();
      check_output("ready_dut", dut, e.dut);
      check_output("ready_source", 32'(is_if), 32'(e.is_if));
      check_output("ready_cycle", cyc, e.cycle);
      if (e.chk_data) begin
         check_output("ready_rdata", rdata, e.data);
      end
   endtask

   // Monitor: every ready pulse is matched against the head of the queue.
   always @(negedge clk) begin
      if (bus4.mem_ready === 1'b1) score(4, 1'b0, bus4.mem_rdata);
      if (bus4.if_ready  === 1'b1) score(4, 1'b1, bus4.if_rdata);
      if (bus1.mem_ready === 1'b1) score(1, 1'b0, bus1.mem_rdata);
      if (bus1.if_ready  === 1'b1) score(1, 1'b1, bus1.if_rdata);
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic apply_stimulus_idle();
      bus4.if_req = 1'b0; bus4.if_addr = '0;
      bus4.mem_rd = 1'b0; bus4.mem_wr = 1'b0; bus4.mem_addr = '0; bus4.mem_wdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0;
      bus1.mem_rd = 1'b0; bus1.mem_wr = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
   endtask

   // Single fetch on the WAIT_CYCLES=4 instance, cycle-by-cycle pin checks.
   task automatic run_fetch(input logic [31:0] addr, input logic [31:0] word);
      int c0;
      @(negedge clk);
      c0 = cyc;
      bus4.if_addr = addr;
      bus4.if_req  = 1'b1;
      expect_ready(4, 1'b1, 1'b1, word, c0 + 5);
      #1 check_output("fetch_freeze_c0", bus4.freeze, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_output("fetch_sram_addr", bus4.sram_addr, addr >> 2);
         check_output("fetch_oe_n", bus4.sram_oe_n, 0);
         check_output("fetch_we_n", bus4.sram_we_n, 1);
         check_output("fetch_freeze_access", bus4.freeze, 1);
      end
      @(negedge clk);
      check_output("fetch_freeze_c5", bus4.freeze, 0);
      check_output("fetch_oe_n_restored", bus4.sram_oe_n, 1);
      bus4.if_req = 1'b0;
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 1024; i++) sram_mem[i] = 32'h0;
      sram_mem[4] = 32'h8C010000;
      sram_mem[2] = 32'h11112222;

      // Reset with a request held: freeze must still be low.
      rst = 1'b0;
      apply_stimulus_idle();
      bus4.if_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_output("rst_freeze", bus4.freeze, 0);
      check_output("rst_we_n", bus4.sram_we_n, 1);
      check_output("rst_oe_n", bus4.sram_oe_n, 1);
      check_output("rst_dq_oe", bus4.sram_dq_oe, 0);
      check_output("rst_addr", bus4.sram_addr, 0);
      check_output("rst_dq_out", bus4.sram_dq_out, 0);
      check_output("rst_if_rdata", bus4.if_rdata, 0);
      check_output("rst_mem_rdata", bus4.mem_rdata, 0);
      check_output("rst_if_ready", bus4.if_ready, 0);
      check_output("rst_mem_ready", bus4.mem_ready, 0);
      bus4.if_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Fetch only.
      run_fetch(32'h10, 32'h8C010000);
      @(negedge clk);

      // Write 0xDEADBEEF to byte address 0x400.
      @(negedge clk);
      c0 = cyc;
      bus4.mem_addr  = 32'h400;
      bus4.mem_wdata = 32'hDEADBEEF;
      bus4.mem_wr    = 1'b1;
      expect_ready(4, 1'b0, 1'b0, 32'h0, c0 + 5);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check_output("wr_we_n", bus4.sram_we_n, 0);
         check_output("wr_dq_oe", bus4.sram_dq_oe, 1);
         check_output("wr_oe_n", bus4.sram_oe_n, 1);
         check_output("wr_addr", bus4.sram_addr, 32'h100);
         check_output("wr_dq_out", bus4.sram_dq_out, 32'hDEADBEEF);
      end
      @(negedge clk);
      check_output("wr_freeze_c5", bus4.freeze, 0);
      check_output("wr_we_n_restored", bus4.sram_we_n, 1);
      check_output("wr_dq_oe_restored", bus4.sram_dq_oe, 0);
      bus4.mem_wr = 1'b0;
      @(negedge clk);
      check_output("wr_sram_word", sram_mem[256], 32'hDEADBEEF);

      // Read it back in the next step.
      c0 = cyc;
      bus4.mem_rd = 1'b1;
      expect_ready(4, 1'b0, 1'b1, 32'hDEADBEEF, c0 + 5);
      @(negedge clk);
      check_output("rd_oe_n", bus4.sram_oe_n, 0);
      repeat (4) @(negedge clk);
      check_output("rd_freeze_c5", bus4.freeze, 0);
      bus4.mem_rd = 1'b0;
      @(negedge clk);

      // Simultaneous data read and fetch: MEM first, then IF.
      c0 = cyc;
      bus4.mem_addr = 32'h400;
      bus4.mem_rd   = 1'b1;
      bus4.if_addr  = 32'h10;
      bus4.if_req   = 1'b1;
      expect_ready(4, 1'b0, 1'b1, 32'hDEADBEEF, c0 + 5);
      expect_ready(4, 1'b1, 1'b1, 32'h8C010000, c0 + 10);
      #1 check_output("both_freeze_c0", bus4.freeze, 1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check_output("both_freeze", bus4.freeze, (k < 10) ? 1 : 0);
         if (k == 6) check_output("both_if_addr", bus4.sram_addr, 4);
      end
      bus4.mem_rd = 1'b0;
      bus4.if_req = 1'b0;
      @(negedge clk);

      // Three back-to-back steps with both requests held throughout.
      c0 = cyc;
      bus4.mem_addr = 32'h8;
      bus4.mem_rd   = 1'b1;
      bus4.if_addr  = 32'h10;
      bus4.if_req   = 1'b1;
      for (int s = 0; s < 3; s++) begin
         expect_ready(4, 1'b0, 1'b1, 32'h11112222, c0 + 11 * s + 5);
         expect_ready(4, 1'b1, 1'b1, 32'h8C010000, c0 + 11 * s + 10);
      end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         check_output("b2b_freeze", bus4.freeze, ((k % 11) != 10) ? 1 : 0);
      end
      bus4.mem_rd = 1'b0;
      bus4.if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in cycle 2 of a write: abort with no ready pulse.
      @(negedge clk);
      bus4.mem_addr  = 32'h20;
      bus4.mem_wdata = 32'hCAFEF00D;
      bus4.mem_wr    = 1'b1;
      @(negedge clk);
      check_output("abort_we_n_before", bus4.sram_we_n, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("abort_we_n", bus4.sram_we_n, 1);
      check_output("abort_dq_oe", bus4.sram_dq_oe, 0);
      check_output("abort_oe_n", bus4.sram_oe_n, 1);
      check_output("abort_freeze", bus4.freeze, 0);
      check_output("abort_addr", bus4.sram_addr, 0);
      check_output("abort_dq_out", bus4.sram_dq_out, 0);
      check_output("abort_mem_rdata", bus4.mem_rdata, 0);
      check_output("abort_if_rdata", bus4.if_rdata, 0);
      bus4.mem_wr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);

      // Normal service after the abort.
      run_fetch(32'h8, 32'h11112222);
      @(negedge clk);

      // WAIT_CYCLES=1 instance: one ACCESS cycle, ready in cycle 2.
      @(negedge clk);
      c0 = cyc;
      bus1.if_addr = 32'h10;
      bus1.if_req  = 1'b1;
      expect_ready(1, 1'b1, 1'b1, 32'h8C010000, c0 + 2);
      #1 check_output("w1_freeze_c0", bus1.freeze, 1);
      @(negedge clk);
      check_output("w1_addr", bus1.sram_addr, 4);
      check_output("w1_oe_n", bus1.sram_oe_n, 0);
      check_output("w1_freeze_c1", bus1.freeze, 1);
      @(negedge clk);
      check_output("w1_freeze_c2", bus1.freeze, 0);
      check_output("w1_oe_n_restored", bus1.sram_oe_n, 1);
      bus1.if_req = 1'b0;

      repeat (3) @(negedge clk);
      check_output("queue_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
